// File: rtl/map_pkg.sv
// Trellis constants and encoder state type shared by the RSC encoder and the MAP decoder.
package map_pkg;

  localparam int unsigned MEM = 2;

  // Generator taps ordered {input/a, D1, D2}.
  localparam logic [2:0] G_FB = 3'b111;
  localparam logic [2:0] G_FF = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_e;

endpackage

// File: rtl/rsc_trellis_step.sv
// One combinational step of the K=3 (7,5) RSC trellis; also used by the decoder's branch-metric unit.
module rsc_trellis_step
  import map_pkg::*;
(
  input  logic u,
  input  logic d1,
  input  logic d2,
  input  logic tail,
  output logic sys,
  output logic par,
  output logic d1_next,
  output logic d2_next
);

  logic fb;
  logic u_eff;
  logic a;

  always_comb begin
    fb = (G_FB[1] & d1) ^ (G_FB[0] & d2);
    // A tail beat feeds the feedback value back in, so a=0 and the register drains to 00.
    u_eff   = tail ? fb : u;
    a       = u_eff ^ fb;
    sys     = u_eff;
    par     = (G_FF[2] & a) ^ (G_FF[1] & d1) ^ (G_FF[0] & d2);
    d1_next = a;
    d2_next = d1;
  end

endmodule

// File: rtl/rsc_tail_encoder.sv
// Rate-1/2 RSC encoder with trellis termination, single-register output stage and frame counter.
module rsc_tail_encoder
  import map_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sys,
  output logic             out_par,
  output logic             out_tail,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

  localparam int unsigned IDX_W = 8;

  enc_state_e       state;
  logic [IDX_W-1:0] idx;
  logic             d1;
  logic             d2;
  logic             ld;
  logic             hs;
  logic             st_tail;
  logic             st_sys;
  logic             st_par;
  logic             st_d1n;
  logic             st_d2n;

  assign st_tail  = (state == TAIL);
  assign ld       = !out_valid | out_ready;
  assign in_ready = ld & !st_tail & !rst;
  assign hs       = in_valid & in_ready;
  // out_last is only set while its beat is pending, so busy covers the drain cycle.
  assign busy     = (state != IDLE) | out_last;

  rsc_trellis_step u_step (
    .u       (in_bit),
    .d1      (d1),
    .d2      (d2),
    .tail    (st_tail),
    .sys     (st_sys),
    .par     (st_par),
    .d1_next (st_d1n),
    .d2_next (st_d2n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      d1          <= 1'b0;
      d2          <= 1'b0;
      out_valid   <= 1'b0;
      out_sys     <= 1'b0;
      out_par     <= 1'b0;
      out_tail    <= 1'b0;
      out_last    <= 1'b0;
      frame_count <= '0;
    end else begin
      if (out_valid & out_ready & out_last)
        frame_count <= frame_count + CNT_W'(1);

      case (state)
        IDLE, DATA: begin
          if (hs) begin
            out_valid <= 1'b1;
            out_sys   <= st_sys;
            out_par   <= st_par;
            out_tail  <= 1'b0;
            out_last  <= 1'b0;
            d1        <= st_d1n;
            d2        <= st_d2n;
            if (idx == IDX_W'(FRAME_LEN - 1)) begin
              state <= TAIL;
              idx   <= '0;
            end else begin
              state <= DATA;
              idx   <= idx + IDX_W'(1);
            end
          end else if (ld) begin
            out_valid <= 1'b0;
            out_sys   <= 1'b0;
            out_par   <= 1'b0;
            out_tail  <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        TAIL: begin
          if (ld) begin
            out_valid <= 1'b1;
            out_sys   <= st_sys;
            out_par   <= st_par;
            out_tail  <= 1'b1;
            out_last  <= (idx == IDX_W'(MEM - 1));
            d1        <= st_d1n;
            d2        <= st_d2n;
            if (idx == IDX_W'(MEM - 1)) begin
              state <= IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsc_tail_encoder.sv
// Directed bench for rsc_tail_encoder with hand-computed (7,5) RSC sequences, FRAME_LEN=4, CNT_W=4.
module tb_rsc_tail_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       out_sys;
  logic       out_par;
  logic       out_tail;
  logic       out_last;
  logic       busy;
  logic [3:0] frame_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [3:0]  fc_exp = '0;

  always #5 clk = ~clk;

  rsc_tail_encoder #(.FRAME_LEN(4), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sys     (out_sys),
    .out_par     (out_par),
    .out_tail    (out_tail),
    .out_last    (out_last),
    .busy        (busy),
    .frame_count (frame_count)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Streams nf frames of u (MSB first); bp selects the 1,0,0,1 out_ready pattern.
  task automatic run_frames(input string tag, input logic [3:0] u, input logic [5:0] se,
                            input logic [5:0] pe, input int unsigned nf, input bit bp);
    int unsigned bi = 0;
    int unsigned bo = 0;
    int unsigned cyc = 0;
    int unsigned b;
    logic [3:0] pat = 4'b1001;
    while (bo < 6 * nf && cyc < 20 * nf + 50) begin
      @(negedge clk);
      out_ready = bp ? pat[3 - (cyc % 4)] : 1'b1;
      if (bi < 4 * nf) begin
        in_valid = 1'b1;
        in_bit   = u[3 - (bi % 4)];
      end else begin
        in_valid = 1'b0;
        in_bit   = 1'b0;
      end
      #1;
      chk({tag, "_fcount"}, 8'(frame_count), 8'(fc_exp));
      if (out_valid) begin
        b = bo % 6;
        chk({tag, "_beat"}, {4'b0, out_sys, out_par, out_tail, out_last},
            {4'b0, se[5 - b], pe[5 - b], (b >= 4) ? 1'b1 : 1'b0, (b == 5) ? 1'b1 : 1'b0});
        if (out_ready) begin
          if (b == 5) begin
            fc_exp = fc_exp + 4'd1;
            if (bi < 4 * nf) chk({tag, "_drain_accept"}, 8'(in_ready), 8'd1);
          end
          bo++;
        end else begin
          chk({tag, "_stall_inready"}, 8'(in_ready), 8'd0);
        end
      end
      if (in_valid && in_ready) bi++;
      cyc++;
    end
    if (bo < 6 * nf) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=%0d expected=%0d beats", tag, bo, 6 * nf);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    #1;
    chk({tag, "_end_fcount"}, 8'(frame_count), 8'(fc_exp));
    chk({tag, "_end_busy"}, 8'(busy), 8'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {1'b0, in_ready, out_valid, out_sys, out_par, out_tail, out_last, busy}, 8'd0);
    chk("rst_fcount", 8'(frame_count), 8'd0);
    rst = 1'b0;

    run_frames("zeros",   4'b0000, 6'b000000, 6'b000000, 1, 1'b0);
    run_frames("impulse", 4'b1000, 6'b100011, 6'b111001, 1, 1'b0);
    run_frames("vector",  4'b1011, 6'b101101, 6'b110011, 1, 1'b0);
    chk("vector_trellis_zero", {6'b0, dut.d1, dut.d2}, 8'd0);
    run_frames("bp",      4'b1011, 6'b101101, 6'b110011, 1, 1'b1);

    // Reset after two accepted bits.
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(negedge clk);
    in_bit   = 1'b0;
    @(negedge clk);
    chk("mid_busy_before_rst", 8'(busy), 8'd1);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", {4'b0, out_valid, busy, in_ready, 1'b0}, 8'd0);
    chk("mid_rst_fcount", 8'(frame_count), 8'd0);
    chk("mid_rst_trellis", {6'b0, dut.d1, dut.d2}, 8'd0);
    rst    = 1'b0;
    fc_exp = '0;
    run_frames("post_rst", 4'b1000, 6'b100011, 6'b111001, 1, 1'b0);

    run_frames("b2b", 4'b1011, 6'b101101, 6'b110011, 17, 1'b0);
    chk("b2b_wrapped", 8'(frame_count), 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
